filter_stream: RTL and testbench

FILTER_STREAM -- requirements
Module: filter_stream

---
 rtl/filter_stream.sv | 193 +++++++++++++++++++
 tb/tb_filter_stream.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_stream.sv
// filter_stream: streaming 2-D FIR (HEIGHT_NB x WIDTH_NB) over a column-per-beat image stream.
//
// Each accepted column of HEIGHT_NB pixels is shifted into a window that holds the last
// WIDTH_NB columns. Every column acceptance yields one result:
//   sum_{h,w} ker[h][w] * win[h][w] (+ bias)
// computed exactly through three register stages (products, per-row sums, total).
//
// Ports (valid/ready handshakes, transfer when val && rdy):
//   clk, rst      clock, synchronous active-high reset
//   cfg_ker/val   kernel words in LOAD, h-major/w-minor, first word is ker[0][0]
//   cfg_rdy       high in LOAD only
//   up_img/val    one pixel column, row h in up_img[h*IMG_WIDTH +: IMG_WIDTH]
//   up_rdy        high in RUN while the output can advance
//   dn_res/val    filter result and its valid
//   dn_rdy        downstream ready
//
// Build option: define FILTER_STREAM_BIAS_EN to load one extra word (an unsigned bias)
// after the kernel; the bias is added in the total-sum stage. Default build has no bias.
module filter_stream #(
  parameter int unsigned HEIGHT_NB = 3,
  parameter int unsigned WIDTH_NB  = 3,
  parameter int unsigned IMG_WIDTH = 8,
  parameter int unsigned KER_WIDTH = 16,
  localparam int unsigned MAC_NB    = HEIGHT_NB * WIDTH_NB,
  localparam int unsigned RES_WIDTH = IMG_WIDTH + KER_WIDTH + $clog2(MAC_NB) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KER_WIDTH-1:0]           cfg_ker,
  input  logic                           cfg_val,
  output logic                           cfg_rdy,
  input  logic [HEIGHT_NB*IMG_WIDTH-1:0] up_img,
  input  logic                           up_val,
  output logic                           up_rdy,
  output logic [RES_WIDTH-1:0]           dn_res,
  output logic                           dn_val,
  input  logic                           dn_rdy
);

`ifdef FILTER_STREAM_BIAS_EN
  localparam int unsigned LoadNb = MAC_NB + 1;
`else
  localparam int unsigned LoadNb = MAC_NB;
`endif
  localparam int unsigned CntW  = $clog2(LoadNb + 1);
  localparam int unsigned ProdW = IMG_WIDTH + KER_WIDTH;

  typedef enum logic [1:0] {StLoad, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Flat tap arrays, index h*WIDTH_NB + w matches the load order.
  logic [KER_WIDTH-1:0]  ker_q  [MAC_NB];
  logic [IMG_WIDTH-1:0]  win_q  [MAC_NB];
  logic                  win_vld_q;
  logic [ProdW-1:0]      prod_q [MAC_NB];
  logic                  prod_vld_q;
  logic [RES_WIDTH-1:0]  row_q  [HEIGHT_NB];
  logic                  row_vld_q;
  logic [RES_WIDTH-1:0]  res_q;
  logic                  res_vld_q;

  logic [RES_WIDTH-1:0]  row_sum [HEIGHT_NB];
  logic [RES_WIDTH-1:0]  tot_sum;
  logic [RES_WIDTH-1:0]  bias_ext;

  logic en, cfg_fire, up_fire, last_word, pipe_empty;

  assign en         = !res_vld_q || dn_rdy;
  assign cfg_rdy    = (state_q == StLoad);
  assign up_rdy     = (state_q == StRun) && en;
  assign cfg_fire   = cfg_val && cfg_rdy;
  assign up_fire    = up_val && up_rdy;
  assign last_word  = (cnt_q == CntW'(LoadNb - 1));
  assign pipe_empty = !win_vld_q && !prod_vld_q && !row_vld_q && !res_vld_q;

  assign dn_res = res_q;
  assign dn_val = res_vld_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (cfg_fire) begin
          if (last_word) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // The cfg word that triggers the drain is left on the bus for the next LOAD.
      StRun:   if (cfg_val) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // ---------------------------------------------------------------- kernel / bias
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      for (int unsigned i = 0; i < MAC_NB; i++) begin
        if (cnt_q == CntW'(i)) ker_q[i] <= cfg_ker;
      end
    end
  end

`ifdef FILTER_STREAM_BIAS_EN
  logic [KER_WIDTH-1:0] bias_q;

  always_ff @(posedge clk) begin
    if (cfg_fire && last_word) bias_q <= cfg_ker;
  end

  assign bias_ext = RES_WIDTH'(bias_q);
`else
  assign bias_ext = '0;
`endif

  // ---------------------------------------------------------------- window
  // Cleared on entry to RUN so taps older than the first new column read as zero.
  always_ff @(posedge clk) begin
    if (rst || (cfg_fire && last_word)) begin
      for (int unsigned i = 0; i < MAC_NB; i++) win_q[i] <= '0;
    end else if (up_fire) begin
      for (int unsigned h = 0; h < HEIGHT_NB; h++) begin
        win_q[h*WIDTH_NB] <= up_img[h*IMG_WIDTH +: IMG_WIDTH];
        for (int unsigned w = 1; w < WIDTH_NB; w++) begin
          win_q[h*WIDTH_NB + w] <= win_q[h*WIDTH_NB + w - 1];
        end
      end
    end
  end

  // ---------------------------------------------------------------- pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      row_vld_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      res_q      <= '0;
    end else if (en) begin
      win_vld_q  <= up_fire;
      prod_vld_q <= win_vld_q;
      row_vld_q  <= prod_vld_q;
      res_vld_q  <= row_vld_q;
      if (row_vld_q) res_q <= tot_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < MAC_NB; i++) begin
        prod_q[i] <= ProdW'(ker_q[i]) * ProdW'(win_q[i]);
      end
      for (int unsigned h = 0; h < HEIGHT_NB; h++) begin
        row_q[h] <= row_sum[h];
      end
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < HEIGHT_NB; h++) begin
      row_sum[h] = '0;
      for (int unsigned w = 0; w < WIDTH_NB; w++) begin
        row_sum[h] = row_sum[h] + RES_WIDTH'(prod_q[h*WIDTH_NB + w]);
      end
    end
  end

  always_comb begin
    tot_sum = bias_ext;
    for (int unsigned h = 0; h < HEIGHT_NB; h++) begin
      tot_sum = tot_sum + row_q[h];
    end
  end

endmodule

// File: tb/tb_filter_stream.sv
// Bench for filter_stream (default parameters). Stimulus pushes expected results into a
// scoreboard queue; an independent monitor pops and compares on every output transfer.
// The reference keeps a history of accepted columns and evaluates the filter sum directly.
module tb_filter_stream;
  localparam int H    = 3;
  localparam int W    = 3;
  localparam int IW   = 8;
  localparam int KW   = 16;
  localparam int MAC  = H * W;
  localparam int RW   = IW + KW + $clog2(MAC) + 1;
`ifdef FILTER_STREAM_BIAS_EN
  localparam int LOADN = MAC + 1;
`else
  localparam int LOADN = MAC;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [KW-1:0]     cfg_ker = '0;
  logic              cfg_val = 1'b0;
  logic              cfg_rdy;
  logic [H*IW-1:0]   up_img = '0;
  logic              up_val = 1'b0;
  logic              up_rdy;
  logic [RW-1:0]     dn_res;
  logic              dn_val;
  logic              dn_rdy = 1'b1;

  filter_stream dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_ker (cfg_ker),
    .cfg_val (cfg_val),
    .cfg_rdy (cfg_rdy),
    .up_img  (up_img),
    .up_val  (up_val),
    .up_rdy  (up_rdy),
    .dn_res  (dn_res),
    .dn_val  (dn_val),
    .dn_rdy  (dn_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------------------------------------------------------- reference model
  typedef struct {
    longint unsigned res;
    int              cyc;
  } exp_t;

  longint unsigned mk [MAC];
  longint unsigned mb = 0;
  logic [H*IW-1:0] hist [$];
  exp_t            sb [$];
  logic [KW-1:0]   kw [LOADN];

  int passed = 0;
  int total  = 0;
  bit strict   = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned expv);
    total++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  function automatic longint unsigned model_res();
    longint unsigned s = mb;
    logic [H*IW-1:0] c;
    for (int w = 0; w < W && w < hist.size(); w++) begin
      c = hist[w];
      for (int h = 0; h < H; h++) s += mk[h*W + w] * 64'(c[h*IW +: IW]);
    end
    return s;
  endfunction

  function automatic logic [H*IW-1:0] mk_col(input logic [IW-1:0] r0, input logic [IW-1:0] r1,
                                              input logic [IW-1:0] r2);
    return {r2, r1, r0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [KW-1:0] word);
    int n = 0;
    cfg_ker = word;
    cfg_val = 1'b1;
    @(negedge clk);
    while (!cfg_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_rdy) begin
      total++;
      $display("FAIL cfg_rdy_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    cfg_val = 1'b0;
  endtask

  task automatic load_kernel();
    for (int i = 0; i < LOADN; i++) begin
      send_cfg(kw[i]);
      if (i < MAC) mk[i] = 64'(kw[i]);
      else mb = 64'(kw[i]);
    end
    hist.delete();
  endtask

  task automatic set_kernel_const(input logic [KW-1:0] v);
    for (int i = 0; i < LOADN; i++) kw[i] = (i < MAC) ? v : '0;
  endtask

  task automatic set_kernel_rand();
    for (int i = 0; i < LOADN; i++) kw[i] = KW'($urandom());
  endtask

  task automatic send_col(input logic [H*IW-1:0] img, input bit use_const,
                          input longint unsigned cexp);
    int   n = 0;
    exp_t e;
    up_img = img;
    up_val = 1'b1;
    @(negedge clk);
    while (!up_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!up_rdy) begin
      total++;
      $display("FAIL up_rdy_timeout: got 0 expected 1");
    end else begin
      hist.push_front(img);
      if (hist.size() > W) void'(hist.pop_back());
      e.res = use_const ? cexp : model_res();
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    up_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || dn_val) && n < 500) begin
      tick();
      n++;
    end
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------- monitor
  bit            hold_pend = 1'b0;
  logic [RW-1:0] held;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_val", 64'(dn_val), 64'd1);
        check("hold_res", 64'(dn_res), 64'(held));
      end
      if (dn_val && dn_rdy) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got %0d expected none", dn_res);
        end else begin
          mon_e = sb.pop_front();
          check("result", 64'(dn_res), mon_e.res);
          if (strict) check("latency", 64'(cyc - mon_e.cyc), 64'd4);
        end
      end
      hold_pend = dn_val && !dn_rdy;
      held      = dn_res;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      dn_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < MAC; i++) mk[i] = 0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    check("rst_up_rdy", 64'(up_rdy), 64'd0);
    check("rst_dn_val", 64'(dn_val), 64'd0);
    check("rst_dn_res", 64'(dn_res), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All-ones kernel, back-to-back columns, exact latency
    set_kernel_const(16'd1);
    load_kernel();
    @(negedge clk);
    check("run_up_rdy", 64'(up_rdy), 64'd1);
    check("run_cfg_rdy", 64'(cfg_rdy), 64'd0);
    tick();
    strict = 1'b1;
    send_col(mk_col(8'd1, 8'd1, 8'd1), 1'b1, 64'd3);
    send_col(mk_col(8'd2, 8'd2, 8'd2), 1'b1, 64'd9);
    send_col(mk_col(8'd3, 8'd3, 8'd3), 1'b1, 64'd18);
    wait_drain();

    // Single tap ker[1][0] = 5
    set_kernel_const(16'd0);
    kw[3] = 16'd5;
    load_kernel();
    send_col(mk_col(8'd7, 8'd200, 8'd9), 1'b1, 64'd1000);
    wait_drain();

    // Maximum operands, no overflow
    set_kernel_const(16'hFFFF);
    load_kernel();
    send_col(mk_col(8'd255, 8'd255, 8'd255), 1'b1, 64'd50134275);
    send_col(mk_col(8'd255, 8'd255, 8'd255), 1'b1, 64'd100268550);
    send_col(mk_col(8'd255, 8'd255, 8'd255), 1'b1, 64'd150402825);
    wait_drain();
    strict = 1'b0;

    // Five-cycle downstream stall mid-stream
    set_kernel_rand();
    load_kernel();
    fork
      begin
        for (int i = 0; i < 12; i++) send_col(H*IW'($urandom()), 1'b0, 64'd0);
      end
      begin
        repeat (5) tick();
        dn_rdy = 1'b0;
        @(negedge clk);
        check("stall_up_rdy", 64'(up_rdy), 64'd0);
        check("stall_dn_val", 64'(dn_val), 64'd1);
        @(posedge clk);
        #1;
        repeat (4) tick();
        dn_rdy = 1'b1;
      end
    join
    wait_drain();

    // Reconfigure while two results are in flight
    send_col(H*IW'($urandom()), 1'b0, 64'd0);
    send_col(H*IW'($urandom()), 1'b0, 64'd0);
    cfg_ker = 16'h1234;
    cfg_val = 1'b1;
    tick();
    @(negedge clk);
    check("drain_cfg_rdy", 64'(cfg_rdy), 64'd0);
    check("drain_up_rdy", 64'(up_rdy), 64'd0);
    cfg_val = 1'b0;
    begin
      int n = 0;
      while (!cfg_rdy && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("drain_to_load", 64'(cfg_rdy), 64'd1);
    check("drain_delivered", 64'(sb.size()), 64'd0);
    check("drain_dn_val", 64'(dn_val), 64'd0);
    @(posedge clk);
    #1;
    set_kernel_rand();
    load_kernel();
    @(negedge clk);
    check("reload_up_rdy", 64'(up_rdy), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) send_col(H*IW'($urandom()), 1'b0, 64'd0);
    wait_drain();

    // Randomised traffic with random backpressure and input gaps
    set_kernel_rand();
    load_kernel();
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_col(H*IW'($urandom()), 1'b0, 64'd0);
      if ($urandom_range(0, 2) == 0) tick();
    end
    rand_rdy = 1'b0;
    tick();
    dn_rdy = 1'b1;
    wait_drain();

    // Reset in the middle of a load restarts at ker[0][0]
    for (int i = 0; i < 4; i++) send_cfg(KW'($urandom()));
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("midrst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    check("midrst_up_rdy", 64'(up_rdy), 64'd0);
    check("midrst_dn_val", 64'(dn_val), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    for (int i = 0; i < LOADN; i++) kw[i] = KW'(i + 1);
    load_kernel();
    send_col(mk_col(8'd1, 8'd0, 8'd0), 1'b1, 64'd1 + mb);
    send_col(H*IW'($urandom()), 1'b0, 64'd0);
    wait_drain();

`ifdef FILTER_STREAM_BIAS_EN
    // Bias only: the tenth word must be taken before RUN
    for (int i = 0; i < MAC; i++) send_cfg(16'd0);
    @(negedge clk);
    check("bias_still_load", 64'(cfg_rdy), 64'd1);
    check("bias_no_up_rdy", 64'(up_rdy), 64'd0);
    send_cfg(16'd100);
    for (int i = 0; i < MAC; i++) mk[i] = 0;
    mb = 100;
    hist.delete();
    @(negedge clk);
    check("bias_run_up_rdy", 64'(up_rdy), 64'd1);
    tick();
    for (int i = 0; i < 5; i++) send_col(H*IW'($urandom()), 1'b1, 64'd100);
    wait_drain();
`endif

    check("final_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
